// File: rtl/priority_1_pkg.sv
// Shared types and codes for the priority_1 driver slice.
//   drv_state_t : driver FSM state encoding (D_IDLE..D_RESP)
//   SEL_*       : exit-select codes driven on sel
//   TMR_W       : width of the D_WAIT timeout counter
//   mode_ok()   : true for the exit modes the driver can execute
package priority_1_pkg;

  typedef enum logic [2:0] {
    D_IDLE = 3'd0,
    D_RUN  = 3'd1,
    D_MID  = 3'd2,
    D_EXIT = 3'd3,
    D_WAIT = 3'd4,
    D_RESP = 3'd5
  } drv_state_t;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_IDLE = 2'd2;
  localparam logic [1:0] SEL_LAST = 2'd3;

  localparam int unsigned TMR_W = 8;

  function automatic logic mode_ok(input logic [1:0] mode);
    return (mode == SEL_IDLE) || (mode == SEL_LAST);
  endfunction

endpackage

// File: rtl/priority_1_drv_timer.sv
// Loadable down-counter with an expired flag, used while waiting for f.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val (has priority over en)
//   en         : decrement by one, holding at zero
//   load_val   : reload value
//   expired_c  : count has reached its last cycle (<= 1), combinational
module priority_1_drv_timer
  import priority_1_pkg::*;
#(
  parameter int unsigned W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  // Flag on the final counted cycle so a load of N gives exactly N wait cycles.
  assign expired_c = (cnt <= W'(1));

endmodule

// File: rtl/priority_1_driver.sv
// Command-driven initiator for the do/sel/f handshake of the priority_1 FSM.
// Converts one {length, exit mode} command into the do/sel drive sequence and
// reports done/error on a one-cycle response pulse.
//   clk, rst_n           : clock, synchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake (cmd_ready is combinational)
//   cmd_len, cmd_mode    : RUN length in cycles, exit code (2=IDLE, 3=LAST)
//   rsp_valid, rsp_err   : registered response pulse and status
//   do_req               : run request to the target ("do" is a reserved word)
//   sel                  : exit select to the target
//   f                    : LAST-state flag from the target
// Optional build macro PRIORITY_1_DRIVER_STATS_EN adds stat_cmds/stat_errs.
module priority_1_driver
  import priority_1_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic [1:0]       cmd_mode,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic             do_req,
  output logic [1:0]       sel,
  input  logic             f
`ifdef PRIORITY_1_DRIVER_STATS_EN
  ,
  output logic [15:0]      stat_cmds,
  output logic [15:0]      stat_errs
`endif
);

  drv_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             err_q, err_d;
  logic             tmr_load, tmr_en, tmr_exp;
  logic             do_d, rsp_valid_d, rsp_err_d;
  logic [1:0]       sel_d;

  priority_1_drv_timer #(.W(TMR_W)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tmr_load),
    .en        (tmr_en),
    .load_val  (TMR_W'(TIMEOUT)),
    .expired_c (tmr_exp)
  );

  assign cmd_ready = (state_q == D_IDLE);

  // State and command registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= D_IDLE;
      cnt_q   <= '0;
      mode_q  <= SEL_NONE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      D_IDLE: begin
        if (cmd_valid) begin
          mode_d = cmd_mode;
          cnt_d  = cmd_len;
          if ((cmd_len == '0) || !mode_ok(cmd_mode)) begin
            err_d   = 1'b1;
            state_d = D_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = D_RUN;
          end
        end
      end
      D_RUN: begin
        // Leave on the last counted cycle; counter never wraps past 1.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = D_MID;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      D_MID: state_d = D_EXIT;
      D_EXIT: begin
        if (mode_q == SEL_LAST) begin
          tmr_load = 1'b1;
          state_d  = D_WAIT;
        end else begin
          err_d   = 1'b0;
          state_d = D_RESP;
        end
      end
      D_WAIT: begin
        tmr_en = 1'b1;
        if (f) begin
          err_d   = 1'b0;
          state_d = D_RESP;
        end else if (tmr_exp) begin
          err_d   = 1'b1;
          state_d = D_RESP;
        end
      end
      D_RESP:  state_d = D_IDLE;
      default: state_d = D_IDLE;
    endcase
  end

  // Output decode: drive values follow the state being entered.
  always_comb begin
    do_d        = (state_d == D_RUN);
    sel_d       = (state_d == D_EXIT) ? mode_d : SEL_NONE;
    rsp_valid_d = (state_q == D_RESP);
    rsp_err_d   = (state_q == D_RESP) && err_q;
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      do_req    <= 1'b0;
      sel       <= SEL_NONE;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      do_req    <= do_d;
      sel       <= sel_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
    end
  end

`ifdef PRIORITY_1_DRIVER_STATS_EN
  // Saturating response/error counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_cmds <= '0;
      stat_errs <= '0;
    end else begin
      if (rsp_valid && (stat_cmds != 16'hFFFF)) stat_cmds <= stat_cmds + 16'd1;
      if (rsp_valid && rsp_err && (stat_errs != 16'hFFFF)) stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_priority_1_driver.sv
// Bench for priority_1_driver paired with a behavioural priority_1 target.
// Responses are checked through an expected-response queue; drive sequences
// and target state are checked cycle by cycle against closed-form timing.
module tb_priority_1_driver;

  localparam int unsigned TIMEOUT = 16;

  typedef enum logic [1:0] {T_IDLE, T_RUN, T_MIDDLE, T_LAST} tgt_state_t;
  typedef struct {
    int   cyc;
    logic err;
  } exp_rsp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_len;
  logic [1:0] cmd_mode;
  logic       rsp_valid, rsp_err;
  logic       do_req;
  logic [1:0] sel;
  logic       f;
  logic       f_zero;
`ifdef PRIORITY_1_DRIVER_STATS_EN
  logic [15:0] stat_cmds, stat_errs;
`endif

  tgt_state_t tgt_state;
  logic       tgt_f;
  exp_rsp_t   sb[$];
  int         cycle;
  int         checks;
  int         errors;

  always #5 clk = ~clk;

  priority_1_driver #(.CNT_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_mode  (cmd_mode),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .do_req    (do_req),
    .sel       (sel),
    .f         (f)
`ifdef PRIORITY_1_DRIVER_STATS_EN
    ,
    .stat_cmds (stat_cmds),
    .stat_errs (stat_errs)
`endif
  );

  // Behavioural priority_1 target; f is the decode of its state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgt_state <= T_IDLE;
    end else begin
      case (tgt_state)
        T_IDLE:   if (do_req) tgt_state <= T_RUN;
        T_RUN:    if (!do_req) tgt_state <= T_MIDDLE;
        T_MIDDLE: begin
          if (sel == 2'd2) tgt_state <= T_IDLE;
          else if (sel == 2'd3) tgt_state <= T_LAST;
        end
        default:  tgt_state <= T_IDLE;
      endcase
    end
  end
  assign tgt_f = (tgt_state == T_LAST);
  assign f     = f_zero ? 1'b0 : tgt_f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // Advance one cycle, sample after the edge, and service the response scoreboard.
  task automatic step();
    @(posedge clk);
    cycle++;
    #1;
    if (sb.size() > 0 && sb[0].cyc == cycle) begin
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_err", 32'(rsp_err), 32'(sb[0].err));
      void'(sb.pop_front());
    end else if (rsp_valid) begin
      chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
    end
  endtask

  // Issue one command from idle and follow it until the driver is idle again.
  task automatic run_cmd(input int len, input logic [1:0] mode, input bit f_kill);
    int         lat;
    logic       err;
    bit         ok;
    logic       exp_do;
    logic [1:0] exp_sel;
    tgt_state_t exp_tgt;
    ok = (len != 0) && (mode == 2'd2 || mode == 2'd3);
    if (!ok) begin
      lat = 1; err = 1'b1;
    end else if (mode == 2'd2) begin
      lat = len + 3; err = 1'b0;
    end else if (f_kill) begin
      lat = len + 3 + int'(TIMEOUT); err = 1'b1;
    end else begin
      lat = len + 4; err = 1'b0;
    end
    f_zero    = f_kill;
    cmd_valid = 1'b1;
    cmd_len   = 8'(len);
    cmd_mode  = mode;
    sb.push_back('{cyc: cycle + 1 + lat, err: err});
    for (int k = 0; k <= lat; k++) begin
      step();
      if (k == 0) cmd_valid = 1'b0;
      exp_do  = ok && (k < len);
      exp_sel = (ok && k == len + 1) ? mode : 2'd0;
      if (!ok || k == 0 || k > len + 2) exp_tgt = T_IDLE;
      else if (k <= len)                exp_tgt = T_RUN;
      else if (k == len + 1)            exp_tgt = T_MIDDLE;
      else                              exp_tgt = (mode == 2'd3) ? T_LAST : T_IDLE;
      chk($sformatf("do_l%0d_m%0d_k%0d", len, mode, k), 32'(do_req), 32'(exp_do));
      chk($sformatf("sel_l%0d_m%0d_k%0d", len, mode, k), 32'(sel), 32'(exp_sel));
      chk($sformatf("tgt_l%0d_m%0d_k%0d", len, mode, k), 32'(tgt_state), 32'(exp_tgt));
      chk($sformatf("rdy_l%0d_m%0d_k%0d", len, mode, k), 32'(cmd_ready), 32'(k >= lat));
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    f_zero = 1'b0;
  endtask

  initial begin
    int acc1, acc2;
    cycle = 0; checks = 0; errors = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_mode = '0; f_zero = 1'b0;
    step(); step();
    chk("rst_do", 32'(do_req), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    step();

    run_cmd(3, 2'd2, 1'b0);    // exit to IDLE
    run_cmd(1, 2'd3, 1'b0);    // exit via LAST, f acknowledged
    run_cmd(2, 2'd3, 1'b1);    // LAST with f suppressed: timeout error
    run_cmd(0, 2'd2, 1'b0);    // zero length rejected
    run_cmd(2, 2'd1, 1'b0);    // illegal mode rejected
    run_cmd(255, 2'd2, 1'b0);  // full-count run
    run_cmd(5, 2'd3, 1'b0);

    // Reset in the middle of RUN abandons the command silently.
    cmd_valid = 1'b1; cmd_len = 8'd8; cmd_mode = 2'd2;
    step();
    cmd_valid = 1'b0;
    step(); step();
    chk("midrst_do_before", 32'(do_req), 32'd1);
    rst_n = 1'b0;
    step();
    chk("midrst_do", 32'(do_req), 32'd0);
    chk("midrst_sel", 32'(sel), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    repeat (12) step();
    run_cmd(4, 2'd2, 1'b0);

    // Back-to-back commands with cmd_valid held, after a fresh reset.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cmd_valid = 1'b1; cmd_len = 8'd2; cmd_mode = 2'd2;
    sb.push_back('{cyc: cycle + 1 + 5, err: 1'b0});
    step();
    acc1 = cycle;
    chk("b2b_acc1_do", 32'(do_req), 32'd1);
    cmd_len = 8'd1; cmd_mode = 2'd3;
    sb.push_back('{cyc: acc1 + 6 + 5, err: 1'b0});
    while (cycle < acc1 + 5) step();
    chk("b2b_ready_at_rsp", 32'(cmd_ready), 32'd1);
    chk("b2b_do_at_rsp", 32'(do_req), 32'd0);
    step();
    acc2 = cycle;
    chk("b2b_acc2_ready", 32'(cmd_ready), 32'd0);
    chk("b2b_acc2_do", 32'(do_req), 32'd1);
    cmd_len = 8'd0; cmd_mode = 2'd2;
    sb.push_back('{cyc: acc2 + 6 + 1, err: 1'b1});
    for (int i = 0; i < 40 && sb.size() > 0; i++) begin
      step();
      if (cycle == acc2 + 6) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    chk("b2b_drained", 32'(sb.size()), 32'd0);
    step(); step();
`ifdef PRIORITY_1_DRIVER_STATS_EN
    chk("stat_cmds", 32'(stat_cmds), 32'd3);
    chk("stat_errs", 32'(stat_errs), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
